// File: rtl/utility_posgen.sv
// Purpose : synchronise a level input, detect a chosen edge and emit a
//           programmable-width pulse in the clk domain.
// Latency : SYNC_STAGES+1 rising edges from first sample to out rising.
// Backpressure: none; out is a free-running strobe, edges arriving while a
//           pulse is active are either dropped or restart the pulse.
//
// Ports:
//   clk  - single clock, all state on the rising edge
//   rst  - synchronous, active-low reset
//   in   - level input (may be asynchronous when SYNC_STAGES > 0)
//   out  - registered pulse output, active high
module utility_posgen #(
    parameter int unsigned SYNC_STAGES  = 2,  // 0..4, 0 = in already synchronous
    parameter int unsigned EDGE_SEL     = 0,  // 0 rising, 1 falling, 2 both
    parameter int unsigned PULSE_CYCLES = 1,  // 1..65535
    parameter bit          RETRIGGER    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    // Counter just wide enough to hold PULSE_CYCLES, never narrower than 1.
    localparam int unsigned CNT_W_RAW = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // Edge select encodings.
    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_BOTH = 2'd2;
    localparam logic [1:0] EDGE_CFG  = 2'(EDGE_SEL);

    // Synchronised version of in, the value the edge detector looks at.
    logic s;

    // ------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            // Input is already in the clk domain; use it directly so the
            // only register before out is the history flop.
            assign s = in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            always_comb begin
                sync_d    = sync_q;
                sync_d[0] = in;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            // During reset every stage loads the raw input, so a level that
            // is held across reset release looks steady and fires nothing.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync_q <= {SYNC_STAGES{in}};
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // History register and edge detection
    // ------------------------------------------------------------------
    logic prev_q;
    logic prev_d;
    logic edge_hit;

    always_comb begin
        prev_d = s;
    end

    always_comb begin
        edge_hit = 1'b0;
        case (EDGE_CFG)
            EDGE_RISE: edge_hit = s & ~prev_q;
            EDGE_FALL: edge_hit = ~s & prev_q;
            EDGE_BOTH: edge_hit = s ^ prev_q;
            // Unused encoding: behave as the default rising-edge detector.
            default:   edge_hit = s & ~prev_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Pulse counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;
    logic             out_d;
    logic             idle;

    assign idle = (cnt_q == CNT_ZERO);

    always_comb begin
        cnt_d = cnt_q;
        if (edge_hit && (idle || RETRIGGER)) begin
            // Start a pulse, or restart the full width when retriggering.
            cnt_d = CNT_LOAD;
        end else if (!idle) begin
            // Edges seen here (including on the last high cycle) are dropped.
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // out is high exactly while the updated count is non-zero, so it rises
    // on the same edge the counter is loaded.
    always_comb begin
        out_d = (cnt_d != CNT_ZERO);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q <= in;
            cnt_q  <= CNT_ZERO;
            out_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_utility_posgen.sv
// Purpose : scoreboard bench for utility_posgen across several configurations.
// Latency : expected pulses are recorded as (start edge time, width in cycles).
// Backpressure: not applicable; the monitor observes out on every falling edge.
module tb_utility_posgen;

    localparam int NDUT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;   // rising edges at 5, 15, 25 ... ns

    logic rst_a;
    logic rst_b;
    logic in_a;
    logic in_b;
    logic in_c;
    logic [NDUT-1:0] out_w;

    // 0: defaults (rising, 1 cycle, 2 stages)
    utility_posgen u_d0 (.clk(clk), .rst(rst_a), .in(in_a), .out(out_w[0]));
    // 1: both edges
    utility_posgen #(.EDGE_SEL(2)) u_d1 (.clk(clk), .rst(rst_a), .in(in_a), .out(out_w[1]));
    // 2: 5-cycle pulse, no retrigger
    utility_posgen #(.PULSE_CYCLES(5), .RETRIGGER(1'b0)) u_d2 (.clk(clk), .rst(rst_a), .in(in_b), .out(out_w[2]));
    // 3: 5-cycle pulse, retrigger
    utility_posgen #(.PULSE_CYCLES(5), .RETRIGGER(1'b1)) u_d3 (.clk(clk), .rst(rst_a), .in(in_b), .out(out_w[3]));
    // 4: 4-cycle pulse, reset mid-pulse
    utility_posgen #(.PULSE_CYCLES(4)) u_d4 (.clk(clk), .rst(rst_b), .in(in_c), .out(out_w[4]));
    // 5: no synchroniser, latency of one edge
    utility_posgen #(.SYNC_STAGES(0)) u_d5 (.clk(clk), .rst(rst_a), .in(in_b), .out(out_w[5]));

    typedef struct {
        int dut;
        int start;
        int width;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    bit active    [NDUT];
    int cur_start [NDUT];
    int cur_width [NDUT];

    task automatic expect_pulse(input int d, input int st, input int w);
        exp_t e;
        e.dut   = d;
        e.start = st;
        e.width = w;
        exp_q.push_back(e);
    endtask

    task automatic check_pulse(input int d, input int st, input int w);
        int idx;
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (idx < 0 && exp_q[k].dut == d) idx = k;
        end
        if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse dut%0d: got pulse start %0d ns width %0d, required no pulse", d, st, w);
        end else begin
            n_checks++;
            if (st != exp_q[idx].start) begin
                n_fail++;
                $display("FAIL pulse_start dut%0d: got %0d ns, required %0d ns", d, st, exp_q[idx].start);
            end
            n_checks++;
            if (w != exp_q[idx].width) begin
                n_fail++;
                $display("FAIL pulse_width dut%0d: got %0d cycles, required %0d cycles", d, w, exp_q[idx].width);
            end
            exp_q.delete(idx);
        end
    endtask

    // Monitor: samples away from the active edge and reports each finished pulse.
    initial begin
        for (int i = 0; i < NDUT; i++) begin
            active[i]    = 1'b0;
            cur_start[i] = 0;
            cur_width[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (out_w[i] === 1'b1) begin
                    if (!active[i]) begin
                        active[i]    = 1'b1;
                        cur_start[i] = int'($time) - 5;
                        cur_width[i] = 0;
                    end
                    cur_width[i]++;
                end else if (active[i]) begin
                    active[i] = 1'b0;
                    check_pulse(i, cur_start[i], cur_width[i]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        in_a  = 1'b1;
        in_b  = 1'b0;
        in_c  = 1'b0;

        // Reset state
        #100;
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (out_w[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out dut%0d: got %b, required 0", i, out_w[i]);
            end
        end

        // Release reset at 200 ns; levels are held so nothing may fire.
        #100;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // in_a falls at 2200 ns: only the both-edge instance pulses.
        #2000;
        in_a = 1'b0;
        expect_pulse(1, 2225, 1);

        // in_a rises at 2400 ns: rising and both-edge instances pulse.
        #200;
        in_a = 1'b1;
        expect_pulse(0, 2425, 1);
        expect_pulse(1, 2425, 1);

        // in_b: one-cycle high at 3000 ns, second rise at 3030 ns
        // (synchronised edges three cycles apart).
        #600;
        in_b = 1'b1;
        expect_pulse(2, 3025, 5);
        expect_pulse(3, 3025, 8);
        expect_pulse(5, 3005, 1);
        expect_pulse(5, 3035, 1);
        #10;
        in_b = 1'b0;
        #20;
        in_b = 1'b1;

        // in_c rises at 4000 ns; reset hits the 2nd high cycle at 4035 ns.
        #970;
        in_c = 1'b1;
        expect_pulse(4, 4025, 1);
        #30;
        rst_b = 1'b0;
        #20;
        rst_b = 1'b1;

        // Let everything settle, then confirm idle outputs and drained queue.
        #500;
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (out_w[i] !== 1'b0 || active[i]) begin
                n_fail++;
                $display("FAIL final_idle dut%0d: got out %b, required 0", i, out_w[i]);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses: got %0d expected pulses never seen (first dut%0d start %0d ns), required 0",
                     exp_q.size(), exp_q[0].dut, exp_q[0].start);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
